// File: rtl/datapath_ctrl_pkg.sv
// Shared control encodings: FSM states, opcodes, ALU operations and immediate formats.
// The datapath ALU and immGen import the same package so the codes stay in one place.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_IALU,
        CL_LW,
        CL_SW,
        CL_BR,
        CL_ILL
    } iclass_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } aluop_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } immsel_t;

    // ALU selection for register and immediate arithmetic; sub only applies to R-type.
    function automatic aluop_t alu_from_funct3(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            3'b001:  return ALU_SLL;
            default: return ALU_SRL;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps the latched IR to class, ALU op,
// immediate format, operand select and the illegal indication.
module ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     iclass,
    output aluop_t      aluop,
    output immsel_t     immsel,
    output logic        alusrc,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        iclass = CL_ILL;
        aluop  = ALU_ADD;
        immsel = IMM_I;
        alusrc = 1'b0;
        case (opcode)
            OP_R: begin
                iclass = CL_R;
                aluop  = alu_from_funct3(funct3, ir[30]);
            end
            OP_IALU: begin
                iclass = CL_IALU;
                aluop  = alu_from_funct3(funct3, 1'b0);
                alusrc = 1'b1;
            end
            OP_LW: if (funct3 == 3'b010) begin
                iclass = CL_LW;
                alusrc = 1'b1;
            end
            OP_SW: if (funct3 == 3'b010) begin
                iclass = CL_SW;
                immsel = IMM_S;
                alusrc = 1'b1;
            end
            OP_BR: if (funct3 == 3'b000 || funct3 == 3'b001) begin
                iclass = CL_BR;
                aluop  = ALU_SUB;
                immsel = IMM_B;
            end
            default: ;
        endcase
        illegal = (iclass == CL_ILL);
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle control FSM for the single-issue datapath: sequences FETCH through WB,
// drives datapath strobes from state and IR, counts retired instructions.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instruction,
    input  logic             zero,
    output logic             PCsrc,
    output logic             ALUsrc,
    output logic             memReadWrite,
    output logic             memToReg,
    output logic             RegWrite,
    output logic [1:0]       immSel,
    output logic [2:0]       ALUop,
    output logic             pc_en,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    state_t     state_q, state_d;
    logic [31:0] ir;
    iclass_t    dec_class;
    aluop_t     dec_aluop;
    immsel_t    dec_immsel;
    logic       dec_alusrc;
    logic       dec_illegal;

    ctrl_decode u_decode (
        .ir      (ir),
        .iclass  (dec_class),
        .aluop   (dec_aluop),
        .immsel  (dec_immsel),
        .alusrc  (dec_alusrc),
        .illegal (dec_illegal)
    );

    assign state = state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir      <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH)
                ir <= instruction;
            if (state_q == S_DECODE && dec_illegal)
                illegal <= 1'b1;
            if (pc_en)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        PCsrc        = 1'b0;
        ALUsrc       = 1'b0;
        memReadWrite = 1'b0;
        memToReg     = 1'b0;
        RegWrite     = 1'b0;
        immSel       = IMM_I;
        ALUop        = ALU_ADD;
        pc_en        = 1'b0;
        busy         = (state_q != S_IDLE) && (state_q != S_HALT);

        // Operand selects hold from DECODE until the instruction's last state.
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ALUsrc = dec_alusrc;
            immSel = dec_immsel;
            ALUop  = dec_aluop;
        end

        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = dec_illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (dec_class)
                    CL_R, CL_IALU: state_d = S_WB;
                    CL_LW, CL_SW:  state_d = S_MEM;
                    CL_BR: begin
                        // funct3[0] distinguishes BNE from BEQ.
                        PCsrc   = ir[12] ? ~zero : zero;
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (dec_class == CL_SW) begin
                    memReadWrite = 1'b1;
                    pc_en        = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                memToReg = (dec_class == CL_LW);
                pc_en    = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

endmodule
